// File: rtl/upsample_row_expander_pkg.sv
// Shared widths and FSM encoding for the 2x nearest-neighbour row upsampler.
package upsample_row_expander_pkg;

  localparam int DEF_PIX_W   = 16;
  localparam int DEF_DATA_R  = 128;
  localparam int DEF_DATA_O  = 256;
  localparam int DEF_DEPTH_R = 11;
  localparam int DEF_ROW_W   = 10;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ROW,
    PASS0,
    SW0,
    PASS1,
    SW1,
    DONE
  } state_t;

endpackage

// File: rtl/upsample_row_expander_if.sv
// Valid/ready output stream carrying upsampled words plus end-of-frame marker.
interface upsample_row_expander_if #(
  parameter int DATA_O = 256
);
  logic              o_valid;
  logic [DATA_O-1:0] o_data;
  logic              i_ready;
  logic              o_last;

  modport master (output o_valid, output o_data, output o_last, input i_ready);
  modport slave  (input o_valid, input o_data, input o_last, output i_ready);
endinterface

// File: rtl/upsample_row_expander_pixel_dup.sv
// Horizontal 2x pixel duplication: input pixel k lands on output pixels 2k and 2k+1.
module upsample_pixel_dup #(
  parameter int PIX_W  = 16,
  parameter int DATA_R = 128,
  parameter int DATA_O = 256
) (
  input  logic [DATA_R-1:0] i_data,
  output logic [DATA_O-1:0] o_data
);

  localparam int NPIX = DATA_R / PIX_W;

  for (genvar k = 0; k < NPIX; k++) begin : g_pix
    assign o_data[(2*k)*PIX_W   +: PIX_W] = i_data[k*PIX_W +: PIX_W];
    assign o_data[(2*k+1)*PIX_W +: PIX_W] = i_data[k*PIX_W +: PIX_W];
  end

endmodule

// File: rtl/upsample_row_expander.sv
// Reads each buffered row twice from a dual-pointer FIFO and streams it out
// pixel-doubled, giving a 2x vertical and horizontal nearest-neighbour upsample.
module upsample_row_expander
  import upsample_row_expander_pkg::*;
#(
  parameter int PIX_W   = DEF_PIX_W,
  parameter int DATA_R  = DEF_DATA_R,
  parameter int DATA_O  = DEF_DATA_O,
  parameter int DEPTH_R = DEF_DEPTH_R,
  parameter int ROW_W   = DEF_ROW_W
) (
  input  logic                 system_clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [DEPTH_R-1:0]   i_row_words,
  input  logic [ROW_W-1:0]     i_row_num,
  output logic                 o_fifo_rden,
  input  logic [DATA_R-1:0]    i_fifo_rddata,
  input  logic                 i_fifo_empty,
  input  logic                 i_fifo_not_ready,
  output logic                 o_change_point,
  output logic [DEPTH_R-1:0]   o_almost_empty_threshold,
  upsample_row_expander_if.master out_if,
  output logic                 o_busy,
  output logic                 o_done
);

  state_t             state_q, state_d;
  logic [DEPTH_R-1:0] word_cnt_q, word_cnt_d;
  logic [DEPTH_R-1:0] row_words_q, row_words_d;
  logic [ROW_W-1:0]   row_cnt_q, row_cnt_d;
  logic [ROW_W-1:0]   row_num_q, row_num_d;
  logic               sw_cnt_q, sw_cnt_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic [DATA_O-1:0]  data_q, data_d;
  logic [DATA_O-1:0]  dup_data;
  logic               pop, row_end, frame_end;

  upsample_pixel_dup #(
    .PIX_W (PIX_W),
    .DATA_R(DATA_R),
    .DATA_O(DATA_O)
  ) u_dup (
    .i_data(i_fifo_rddata),
    .o_data(dup_data)
  );

  always_comb begin
    state_d        = state_q;
    word_cnt_d     = word_cnt_q;
    row_words_d    = row_words_q;
    row_cnt_d      = row_cnt_q;
    row_num_d      = row_num_q;
    sw_cnt_d       = sw_cnt_q;
    valid_d        = valid_q;
    last_d         = last_q;
    data_d         = data_q;
    o_change_point = 1'b0;
    o_done         = 1'b0;

    pop       = (state_q == PASS0 || state_q == PASS1) && !i_fifo_empty &&
                (!valid_q || out_if.i_ready);
    row_end   = (word_cnt_q == row_words_q - DEPTH_R'(1));
    frame_end = (row_cnt_q == row_num_q - ROW_W'(1));

    if (valid_q && out_if.i_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
    if (pop) begin
      valid_d    = 1'b1;
      data_d     = dup_data;
      last_d     = (state_q == PASS1) && row_end && frame_end;
      word_cnt_d = row_end ? '0 : word_cnt_q + DEPTH_R'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          row_words_d = i_row_words;
          row_num_d   = i_row_num;
          row_cnt_d   = '0;
          word_cnt_d  = '0;
          state_d     = WAIT_ROW;
        end
      end
      WAIT_ROW: if (!i_fifo_not_ready) state_d = PASS0;
      PASS0:    if (pop && row_end) state_d = SW0;
      PASS1:    if (pop && row_end) state_d = SW1;
      // First switch cycle flips the FIFO pointer; second covers RAM read latency.
      SW0: begin
        o_change_point = !sw_cnt_q;
        sw_cnt_d       = !sw_cnt_q;
        if (sw_cnt_q) state_d = PASS1;
      end
      SW1: begin
        o_change_point = !sw_cnt_q;
        sw_cnt_d       = !sw_cnt_q;
        if (sw_cnt_q) begin
          row_cnt_d = row_cnt_q + ROW_W'(1);
          state_d   = frame_end ? DONE : WAIT_ROW;
        end
      end
      DONE: begin
        if (!valid_q) begin
          o_done  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      word_cnt_q  <= '0;
      row_words_q <= '0;
      row_cnt_q   <= '0;
      row_num_q   <= '0;
      sw_cnt_q    <= 1'b0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      row_words_q <= row_words_d;
      row_cnt_q   <= row_cnt_d;
      row_num_q   <= row_num_d;
      sw_cnt_q    <= sw_cnt_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      data_q      <= data_d;
    end
  end

  assign o_fifo_rden              = pop;
  assign o_almost_empty_threshold = row_words_q;
  assign o_busy                   = (state_q != IDLE);
  assign out_if.o_valid           = valid_q;
  assign out_if.o_data            = data_q;
  assign out_if.o_last            = last_q;

endmodule

// File: tb/tb_upsample_row_expander.sv
// Scoreboard bench for upsample_row_expander with a behavioural dual-pointer FIFO.
module tb_upsample_row_expander;

  logic         clk;
  logic         rst_n;
  logic         tb_start;
  logic [10:0]  tb_row_words;
  logic [9:0]   tb_row_num;
  logic         tb_ready;
  logic         empty_force;
  logic         o_fifo_rden;
  logic [127:0] fifo_rddata;
  logic         fifo_empty;
  logic         fifo_not_ready;
  logic         o_change_point;
  logic [10:0]  o_threshold;
  logic         o_busy;
  logic         o_done;

  upsample_row_expander_if #(.DATA_O(256)) out_if ();

  upsample_row_expander dut (
    .system_clk              (clk),
    .rst_n                   (rst_n),
    .i_start                 (tb_start),
    .i_row_words             (tb_row_words),
    .i_row_num               (tb_row_num),
    .o_fifo_rden             (o_fifo_rden),
    .i_fifo_rddata           (fifo_rddata),
    .i_fifo_empty            (fifo_empty),
    .i_fifo_not_ready        (fifo_not_ready),
    .o_change_point          (o_change_point),
    .o_almost_empty_threshold(o_threshold),
    .out_if                  (out_if.master),
    .o_busy                  (o_busy),
    .o_done                  (o_done)
  );

  assign out_if.i_ready = tb_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FIFO: virtual pointer checks row occupancy, real pointer rereads.
  logic [127:0] mem [0:2047];
  logic [31:0]  wr_ptr, rd_real, rd_virt, head_ptr;
  logic         sel_virt, model_empty;

  assign head_ptr       = sel_virt ? rd_virt : rd_real;
  assign model_empty    = (wr_ptr == head_ptr);
  assign fifo_empty     = model_empty | empty_force;
  assign fifo_rddata    = mem[head_ptr[10:0]];
  assign fifo_not_ready = (wr_ptr - head_ptr) < {21'd0, o_threshold};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_real  <= 32'd0;
      rd_virt  <= 32'd0;
      sel_virt <= 1'b1;
    end else begin
      if (o_fifo_rden) begin
        if (sel_virt) rd_virt <= rd_virt + 32'd1;
        else          rd_real <= rd_real + 32'd1;
      end
      if (o_change_point) sel_virt <= ~sel_virt;
    end
  end

  int tests_run = 0;
  int fails     = 0;

  logic [255:0] sb_data[$];
  logic         sb_last[$];
  logic [127:0] pend[$];

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [255:0] dup_model(input logic [127:0] w);
    logic [255:0] r;
    for (int j = 0; j < 16; j++) r[16*j +: 16] = w[16*(j/2) +: 16];
    return r;
  endfunction

  task automatic fifo_write(input logic [127:0] w);
    mem[wr_ptr[10:0]] = w;
    wr_ptr = wr_ptr + 32'd1;
  endtask

  // Build a frame: write the first prewrite words, hold the rest, queue expectations.
  task automatic push_frame(input int rw, input int rn, input bit counting, input int prewrite);
    logic [127:0] row_buf[$];
    logic [127:0] w;
    int n;
    n = 0;
    for (int r = 0; r < rn; r++) begin
      row_buf.delete();
      for (int k = 0; k < rw; k++) begin
        if (counting) w = {8{16'(k + 1)}};
        else          w = {$urandom, $urandom, $urandom, $urandom};
        row_buf.push_back(w);
        if (n < prewrite) fifo_write(w);
        else              pend.push_back(w);
        n++;
      end
      for (int p = 0; p < 2; p++)
        for (int k = 0; k < rw; k++) begin
          sb_data.push_back(dup_model(row_buf[k]));
          sb_last.push_back(p == 1 && r == rn - 1 && k == rw - 1);
        end
    end
  endtask

  task automatic start_frame(input string name, input int rw, input int rn);
    @(negedge clk);
    tb_start     = 1'b1;
    tb_row_words = 11'(rw);
    tb_row_num   = 10'(rn);
    @(negedge clk);
    tb_start = 1'b0;
    #1;
    tests_run++;
    if (o_threshold !== 11'(rw) || o_busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL %s start: threshold=%0d busy=%b, required threshold=%0d busy=1",
               name, o_threshold, o_busy, rw);
    end
  endtask

  task automatic run_frame(input string name, input int rw, input int rn, input int budget,
                           input int ready_after, input int ready_len,
                           input int empty_after, input int empty_len, input int restart_at);
    int cyc, acc, pops, cps, dones, done_cyc, empty_reads, ready_left, empty_left;
    bit ready_fired, empty_fired, prev_hold;
    logic [255:0] held, exp_d;
    logic exp_l;
    cyc = 0; acc = 0; pops = 0; cps = 0; dones = 0; done_cyc = 0; empty_reads = 0;
    ready_left = 0; empty_left = 0; ready_fired = 0; empty_fired = 0; prev_hold = 0;
    held = '0;
    while (cyc < budget && !(dones > 0 && cyc >= done_cyc + 4)) begin
      @(negedge clk);
      cyc++;
      if (!ready_fired && ready_len > 0 && acc >= ready_after) begin
        ready_fired = 1; ready_left = ready_len;
      end
      tb_ready = (ready_left == 0);
      if (ready_left > 0) ready_left--;
      if (!empty_fired && empty_len > 0 && pops >= empty_after) begin
        empty_fired = 1; empty_left = empty_len;
      end
      empty_force = (empty_left > 0);
      if (empty_left > 0) empty_left--;
      tb_start = (restart_at > 0 && cyc == restart_at);
      if (tb_start) begin
        tb_row_words = 11'd7;
        tb_row_num   = 10'd5;
      end
      #1;
      if (o_fifo_rden) begin
        pops++;
        if (fifo_empty) empty_reads++;
      end
      if (o_change_point) cps++;
      if (o_done) begin
        dones++;
        done_cyc = cyc;
      end
      if (prev_hold) begin
        tests_run++;
        if (out_if.o_valid !== 1'b1 || out_if.o_data !== held) begin
          fails++;
          $display("[TB] FAIL %s hold: valid=%b data=%h, required valid=1 data=%h",
                   name, out_if.o_valid, out_if.o_data, held);
        end
      end
      if (out_if.o_valid === 1'b1 && tb_ready) begin
        acc++;
        tests_run++;
        if (sb_data.size() == 0) begin
          fails++;
          $display("[TB] FAIL %s word %0d: unexpected output data=%h", name, acc, out_if.o_data);
        end else begin
          exp_d = sb_data.pop_front();
          exp_l = sb_last.pop_front();
          if (out_if.o_data !== exp_d || out_if.o_last !== exp_l) begin
            fails++;
            $display("[TB] FAIL %s word %0d: data=%h last=%b, required data=%h last=%b",
                     name, acc, out_if.o_data, out_if.o_last, exp_d, exp_l);
          end
        end
      end
      prev_hold = (out_if.o_valid === 1'b1) && !tb_ready;
      held      = out_if.o_data;
    end
    tb_ready = 1'b1; empty_force = 1'b0; tb_start = 1'b0;

    tests_run++;
    if (dones == 0) begin
      fails++;
      $display("[TB] FAIL %s timeout: no o_done within %0d cycles", name, budget);
    end
    tests_run++;
    if (acc !== 2*rw*rn || pops !== 2*rw*rn || sb_data.size() !== 0) begin
      fails++;
      $display("[TB] FAIL %s totals: words=%0d pops=%0d left=%0d, required words=pops=%0d left=0",
               name, acc, pops, sb_data.size(), 2*rw*rn);
    end
    tests_run++;
    if (cps !== 2*rn || dones !== 1 || sel_virt !== 1'b1) begin
      fails++;
      $display("[TB] FAIL %s events: change_points=%0d dones=%0d sel_virt=%b, required %0d/1/1",
               name, cps, dones, sel_virt, 2*rn);
    end
    tests_run++;
    if (o_busy !== 1'b0 || empty_reads !== 0) begin
      fails++;
      $display("[TB] FAIL %s end: busy=%b empty_reads=%0d, required busy=0 empty_reads=0",
               name, o_busy, empty_reads);
    end
  endtask

  task automatic check_reset_values(input string name);
    tests_run++;
    if (out_if.o_valid !== 1'b0 || out_if.o_data !== '0 || out_if.o_last !== 1'b0 ||
        o_done !== 1'b0 || o_busy !== 1'b0 || o_fifo_rden !== 1'b0 ||
        o_change_point !== 1'b0 || o_threshold !== 11'd0) begin
      fails++;
      $display("[TB] FAIL %s: valid=%b data=%h last=%b done=%b busy=%b rden=%b cp=%b thr=%0d, required all zero",
               name, out_if.o_valid, out_if.o_data, out_if.o_last, o_done, o_busy,
               o_fifo_rden, o_change_point, o_threshold);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_reset_values("idle_after_reset");
  endtask

  task automatic test_basic();
    push_frame(4, 1, 1'b1, 4);
    start_frame("basic", 4, 1);
    run_frame("basic", 4, 1, 200, 0, 0, 0, 0, 0);
  endtask

  task automatic test_stall();
    push_frame(3, 2, 1'b0, 6);
    start_frame("stall", 3, 2);
    run_frame("stall", 3, 2, 300, 1, 5, 0, 0, 4);
    tests_run++;
    if (o_threshold !== 11'd3) begin
      fails++;
      $display("[TB] FAIL stall restart_ignored: threshold=%0d, required 3", o_threshold);
    end
  endtask

  task automatic test_wait_row();
    push_frame(4, 1, 1'b0, 2);
    start_frame("wait_row", 4, 1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      tests_run++;
      if (o_fifo_rden !== 1'b0 || o_busy !== 1'b1 || out_if.o_valid !== 1'b0) begin
        fails++;
        $display("[TB] FAIL wait_row cycle %0d: rden=%b busy=%b valid=%b, required 0/1/0",
                 c, o_fifo_rden, o_busy, out_if.o_valid);
      end
    end
    while (pend.size() > 0) fifo_write(pend.pop_front());
    run_frame("wait_row", 4, 1, 200, 0, 0, 0, 0, 0);
  endtask

  task automatic test_empty_stall();
    push_frame(4, 1, 1'b0, 4);
    start_frame("empty_stall", 4, 1);
    run_frame("empty_stall", 4, 1, 200, 0, 0, 5, 3, 0);
  endtask

  task automatic test_wrap();
    push_frame(1024, 1, 1'b0, 1024);
    start_frame("wrap", 1024, 1);
    run_frame("wrap", 1024, 1, 5000, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    bit seen, reached;
    int wait_c;
    seen = 0; reached = 0; wait_c = 0;
    push_frame(4, 2, 1'b0, 8);
    start_frame("reset_mid", 4, 2);
    for (int c = 0; c < 200 && !reached; c++) begin
      @(negedge clk);
      #1;
      if (o_change_point) seen = 1;
      else if (seen) begin
        wait_c++;
        if (wait_c == 3) reached = 1;
      end
    end
    tests_run++;
    if (!reached || o_busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_mid reach_pass1: reached=%0d busy=%b, required 1/1", reached, o_busy);
    end
    rst_n = 1'b0;
    #1;
    check_reset_values("reset_mid");
    @(negedge clk);
    #1;
    check_reset_values("reset_mid_held");
    rst_n = 1'b1;
    wr_ptr = 32'd0;
    sb_data.delete();
    sb_last.delete();
    pend.delete();
    push_frame(2, 1, 1'b0, 2);
    start_frame("after_reset", 2, 1);
    run_frame("after_reset", 2, 1, 200, 0, 0, 0, 0, 0);
  endtask

  initial begin
    tb_start     = 1'b0;
    tb_row_words = 11'd0;
    tb_row_num   = 10'd0;
    tb_ready     = 1'b1;
    empty_force  = 1'b0;
    wr_ptr       = 32'd0;
    rst_n        = 1'b0;

    test_reset();
    test_basic();
    test_stall();
    test_wait_row();
    test_empty_stall();
    test_wrap();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
